button_press_classifier: RTL and testbench

// Consumes the debounced level from Sync_And_Debounce and turns it into discrete user events.
// A press shorter than LONG_PRESS_CYCLES yields a short_press pulse on release.
// A press held for LONG_PRESS_CYCLES yields a long_press pulse while still held.

---
 rtl/button_press_classifier_if.sv | 23 ++
 rtl/button_press_classifier.sv | 140 ++++++++++++++
 tb/tb_button_press_classifier.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/button_press_classifier_if.sv
// rtl/button_press_classifier_if.sv - button level in, classified press events out
interface button_press_classifier_if #(
  parameter int EVENT_WIDTH = 8
);
  logic                   debounced;
  logic                   short_press;
  logic                   long_press;
  logic                   repeat_pulse;
  logic                   held;
  logic [EVENT_WIDTH-1:0] event_count;

  // master drives the button level and observes events
  modport master (
    output debounced,
    input  short_press, long_press, repeat_pulse, held, event_count
  );

  // slave is the classifier itself
  modport slave (
    input  debounced,
    output short_press, long_press, repeat_pulse, held, event_count
  );
endinterface

// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - short/long press classifier, optional AUTO_REPEAT_EN auto-repeat
module button_press_classifier #(
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int REPEAT_CYCLES     = 200,
  parameter int COUNT_WIDTH       = 16,
  parameter int EVENT_WIDTH       = 8
) (
  input  logic                       control_clock,
  input  logic                       control_reset,
  button_press_classifier_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_ARM       = 2'd0,
    ST_IDLE      = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_LONG_HELD = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] HOLD_LAST = COUNT_WIDTH'(LONG_PRESS_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic                   short_q, short_d;
  logic                   long_q, long_d;
  logic                   held_q, held_d;
  logic [EVENT_WIDTH-1:0] evt_q, evt_d;

`ifdef AUTO_REPEAT_EN
  localparam logic [COUNT_WIDTH-1:0] REP_LAST = COUNT_WIDTH'(REPEAT_CYCLES - 1);
  logic [COUNT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
  logic                   rep_q, rep_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_CYCLES > 0);
`endif

  // state and registered outputs; reset leaves the FSM in ARM so a held button is ignored
  always_ff @(posedge control_clock) begin
    if (control_reset) begin
      state_q    <= ST_ARM;
      hold_cnt_q <= '0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      held_q     <= 1'b0;
      evt_q      <= '0;
`ifdef AUTO_REPEAT_EN
      rep_cnt_q  <= '0;
      rep_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      short_q    <= short_d;
      long_q     <= long_d;
      held_q     <= held_d;
      evt_q      <= evt_d;
`ifdef AUTO_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
      rep_q      <= rep_d;
`endif
    end
  end

  // next-state: release takes priority over the long-press threshold
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARM:       if (!bus.debounced) state_d = ST_IDLE;
      ST_IDLE:      if (bus.debounced)  state_d = ST_PRESSED;
      ST_PRESSED: begin
        if (!bus.debounced)             state_d = ST_IDLE;
        else if (hold_cnt_q == HOLD_LAST) state_d = ST_LONG_HELD;
      end
      ST_LONG_HELD: if (!bus.debounced) state_d = ST_IDLE;
      default:                          state_d = ST_ARM;
    endcase
  end

  // output and counter next values; pulses default low so each lasts one cycle
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    short_d    = 1'b0;
    long_d     = 1'b0;
    held_d     = held_q;
`ifdef AUTO_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    rep_d      = 1'b0;
`endif
    case (state_q)
      ST_ARM: held_d = 1'b0;
      ST_IDLE: begin
        if (bus.debounced) begin
          hold_cnt_d = '0;
          held_d     = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!bus.debounced) begin
          short_d = 1'b1;
          held_d  = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          long_d = 1'b1;
`ifdef AUTO_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (!bus.debounced) begin
          held_d = 1'b0;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (rep_cnt_q == REP_LAST) begin
            rep_d     = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
`endif
        end
      end
      default: held_d = 1'b0;
    endcase
    evt_d = (short_d || long_d) ? evt_q + 1'b1 : evt_q;
  end

  assign bus.short_press = short_q;
  assign bus.long_press  = long_q;
  assign bus.held        = held_q;
  assign bus.event_count = evt_q;
`ifdef AUTO_REPEAT_EN
  assign bus.repeat_pulse = rep_q;
`else
  assign bus.repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// tb/tb_button_press_classifier.sv - press classifier bench against a run-length reference model
module tb_button_press_classifier;

  localparam int L  = 8;
  localparam int R  = 4;
  localparam int EW = 8;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  button_press_classifier_if #(.EVENT_WIDTH(EW)) bus ();

  button_press_classifier #(
    .LONG_PRESS_CYCLES(L),
    .REPEAT_CYCLES    (R),
    .COUNT_WIDTH      (16),
    .EVENT_WIDTH      (EW)
  ) dut (
    .control_clock(clk),
    .control_reset(rst),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  // reference model: a press is a run of 1 samples; its length decides the event
  bit blocked = 1'b1;
  bit in_press = 1'b0;
  bit is_long = 1'b0;
  int run_len = 0;
  int evt = 0;
  bit e_short = 1'b0, e_long = 1'b0, e_rep = 1'b0, e_held = 1'b0;

  task automatic model_edge(input bit d, input bit r);
    e_short = 1'b0;
    e_long  = 1'b0;
    e_rep   = 1'b0;
    if (r) begin
      blocked = 1'b1; in_press = 1'b0; is_long = 1'b0; run_len = 0;
      e_held = 1'b0; evt = 0;
    end else if (blocked) begin
      if (!d) blocked = 1'b0;
    end else if (!in_press) begin
      if (d) begin
        in_press = 1'b1; run_len = 1; is_long = 1'b0; e_held = 1'b1;
      end
    end else if (!d) begin
      if (!is_long) begin
        e_short = 1'b1;
        evt = (evt + 1) % (1 << EW);
      end
      in_press = 1'b0;
      e_held = 1'b0;
    end else begin
      run_len++;
      if (run_len == L + 1) begin
        is_long = 1'b1;
        e_long = 1'b1;
        evt = (evt + 1) % (1 << EW);
      end else if (is_long && ((run_len - (L + 1)) % R == 0)) begin
        e_rep = AUTO;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    compared++;
    assert (bus.short_press === e_short) else begin
      mismatched++;
      $error("FAIL %s short_press observed=%0b expected=%0b", tag, bus.short_press, e_short);
    end
    compared++;
    assert (bus.long_press === e_long) else begin
      mismatched++;
      $error("FAIL %s long_press observed=%0b expected=%0b", tag, bus.long_press, e_long);
    end
    compared++;
    assert (bus.repeat_pulse === e_rep) else begin
      mismatched++;
      $error("FAIL %s repeat_pulse observed=%0b expected=%0b", tag, bus.repeat_pulse, e_rep);
    end
    compared++;
    assert (bus.held === e_held) else begin
      mismatched++;
      $error("FAIL %s held observed=%0b expected=%0b", tag, bus.held, e_held);
    end
    compared++;
    assert (bus.event_count === EW'(evt)) else begin
      mismatched++;
      $error("FAIL %s event_count observed=%0d expected=%0d", tag, bus.event_count, evt);
    end
  endtask

  // one clock edge with the given level and reset, then compare against the model
  task automatic step(input bit d, input bit r, input string tag);
    @(negedge clk);
    bus.debounced = d;
    rst = r;
    @(posedge clk);
    model_edge(d, r);
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input bit d, input int n, input string tag);
    for (int i = 0; i < n; i++) step(d, 1'b0, tag);
  endtask

  int start_evt;
  int cnt_long, cnt_short;

  initial begin
    bus.debounced = 1'b0;

    step(1'b0, 1'b1, "reset");
    drive(1'b0, 3, "idle");

    // short press of 3 samples
    drive(1'b1, 3, "t1_hold");
    drive(1'b0, 3, "t1_release");
    compared++;
    assert (bus.event_count === 8'd1) else begin
      mismatched++;
      $error("FAIL t1_count observed=%0d expected=1", bus.event_count);
    end

    // long hold of 20 samples
    drive(1'b1, 20, "t2_hold");
    drive(1'b0, 3, "t2_release");

    // release sampled on the threshold edge stays short
    drive(1'b1, 8, "t3_hold");
    drive(1'b0, 3, "t3_release");

    // button held through reset is ignored until released
    drive(1'b1, 2, "t4_pre");
    step(1'b1, 1'b1, "t4_reset");
    drive(1'b1, 30, "t4_held");
    drive(1'b0, 2, "t4_release");
    drive(1'b1, 2, "t4_press");
    drive(1'b0, 2, "t4_release2");

    // reset mid-press with hold counter at 5
    drive(1'b1, 6, "t5_press");
    step(1'b1, 1'b1, "t5_reset");
    drive(1'b1, 2, "t5_after");
    drive(1'b0, 3, "t5_release");
    compared++;
    assert (bus.event_count === 8'd0) else begin
      mismatched++;
      $error("FAIL t5_count observed=%0d expected=0", bus.event_count);
    end

    // long hold with repeats when enabled
    drive(1'b1, 20, "t6_hold");
    drive(1'b0, 2, "t6_release");

    // 1-cycle presses back to back: counter wraps after 256
    start_evt = evt;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, "wrap_press");
      step(1'b0, 1'b0, "wrap_release");
    end
    compared++;
    assert (bus.event_count === EW'(start_evt)) else begin
      mismatched++;
      $error("FAIL wrap_count observed=%0d expected=%0d", bus.event_count, start_evt);
    end

    // randomized run lengths around the threshold, with occasional resets
    cnt_long = 0;
    cnt_short = 0;
    for (int k = 0; k < 120; k++) begin
      int hi_len;
      int lo_len;
      hi_len = $urandom_range(1, L + 3 * R);
      lo_len = $urandom_range(1, 4);
      for (int j = 0; j < hi_len; j++) begin
        bit r;
        r = ($urandom_range(0, 99) == 0);
        step(1'b1, r, "rand_hi");
        cnt_long += e_long;
      end
      for (int j = 0; j < lo_len; j++) begin
        step(1'b0, 1'b0, "rand_lo");
        cnt_short += e_short;
      end
    end
    compared++;
    assert (cnt_long > 0 && cnt_short > 0) else begin
      mismatched++;
      $error("FAIL rand_coverage observed long=%0d short=%0d expected both nonzero", cnt_long, cnt_short);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
